// File: rtl/cfg_types_pkg.sv
// Shared types and the round-robin helper for the accelerator data-memory arbiter.
package cfg_types_pkg;

  typedef enum logic [1:0] {
    ARB_RR      = 2'd0,
    ARB_LOCK    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_AXI = 1'b0,
    OWN_ACC = 1'b1
  } arb_owner_t;

  // Read-return steering record captured at grant time
  typedef struct packed {
    logic       valid;
    arb_owner_t owner;
  } rsel_t;

  // Fair pick: a lone requester wins, on contention the one that did not win last
  function automatic arb_owner_t rr_pick(input arb_owner_t last,
                                         input logic       axi_req,
                                         input logic       acc_req);
    arb_owner_t pick;
    pick = OWN_AXI;
    if (axi_req && acc_req) begin
      pick = (last == OWN_AXI) ? OWN_ACC : OWN_AXI;
    end else if (acc_req) begin
      pick = OWN_ACC;
    end
    return pick;
  endfunction

endpackage

// File: rtl/accel_mem_arbiter.sv
// Shares the single-port accelerator data SRAM between the AXI-side port and the
// accelerator core, with round-robin fairness and a capped accelerator burst lock.
module accel_mem_arbiter
  import cfg_types_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    axi_req,
  output logic                    axi_gnt,
  input  logic [ADDR_WIDTH-1:0]   axi_addr,
  input  logic                    axi_we,
  input  logic [DATA_WIDTH/8-1:0] axi_be,
  input  logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic                    axi_rvalid,
  output logic [DATA_WIDTH-1:0]   axi_rdata,
  input  logic                    acc_req,
  output logic                    acc_gnt,
  input  logic [ADDR_WIDTH-1:0]   acc_addr,
  input  logic                    acc_we,
  input  logic [DATA_WIDTH/8-1:0] acc_be,
  input  logic [DATA_WIDTH-1:0]   acc_wdata,
  output logic                    acc_rvalid,
  output logic [DATA_WIDTH-1:0]   acc_rdata,
  input  logic                    acc_lock,
  output logic                    mem_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    cnt_clr,
  output logic [CNT_WIDTH-1:0]    conflict_cnt
);

  localparam int unsigned BURST_WIDTH = $clog2(MAX_BURST + 1);

  arb_state_t             state_q, state_d;
  arb_owner_t             last_q, last_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;
  rsel_t                  rsel_q, rsel_d;
  logic [CNT_WIDTH-1:0]   cnt_q;

  logic       grant_any;
  arb_owner_t winner;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_RR;
      last_q  <= OWN_AXI;
      burst_q <= '0;
      rsel_q  <= '{valid: 1'b0, owner: OWN_AXI};
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      rsel_q  <= rsel_d;
    end
  end

  // Grant decision and next state
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    burst_d   = burst_q;
    grant_any = 1'b0;
    winner    = OWN_AXI;

    unique case (state_q)
      ARB_RR: begin
        grant_any = axi_req | acc_req;
        winner    = rr_pick(last_q, axi_req, acc_req);
        if (grant_any && (winner == OWN_ACC) && acc_lock) begin
          state_d = ARB_LOCK;
          burst_d = BURST_WIDTH'(1);
        end
      end
      ARB_LOCK: begin
        if (acc_req && acc_lock) begin
          grant_any = 1'b1;
          winner    = OWN_ACC;
          if (burst_q == BURST_WIDTH'(MAX_BURST - 1)) begin
            state_d = ARB_RELEASE;
            burst_d = '0;
          end else begin
            burst_d = burst_q + BURST_WIDTH'(1);
          end
        end else begin
          grant_any = axi_req | acc_req;
          winner    = rr_pick(last_q, axi_req, acc_req);
          state_d   = ARB_RR;
          burst_d   = '0;
        end
      end
      ARB_RELEASE: begin
        // Forced release: AXI gets the slot if it wants it
        grant_any = axi_req | acc_req;
        winner    = axi_req ? OWN_AXI : OWN_ACC;
        state_d   = ARB_RR;
        burst_d   = '0;
      end
      default: begin
        state_d = ARB_RR;
        burst_d = '0;
      end
    endcase

    if (!rst_n) begin
      grant_any = 1'b0;
    end
    if (grant_any) begin
      last_d = winner;
    end
  end

  assign axi_gnt = grant_any && (winner == OWN_AXI);
  assign acc_gnt = grant_any && (winner == OWN_ACC);
  assign mem_en  = grant_any;

  // Memory-side mux follows the winner
  always_comb begin
    mem_addr  = axi_addr;
    mem_we    = axi_we;
    mem_be    = axi_be;
    mem_wdata = axi_wdata;
    if (winner == OWN_ACC) begin
      mem_addr  = acc_addr;
      mem_we    = acc_we;
      mem_be    = acc_be;
      mem_wdata = acc_wdata;
    end
  end

  always_comb begin
    rsel_d       = rsel_q;
    rsel_d.valid = grant_any & ~mem_we;
    rsel_d.owner = winner;
  end

  // Only rvalid is steered; data goes to both sides
  assign axi_rvalid = rst_n & rsel_q.valid & (rsel_q.owner == OWN_AXI);
  assign acc_rvalid = rst_n & rsel_q.valid & (rsel_q.owner == OWN_ACC);
  assign axi_rdata  = mem_rdata;
  assign acc_rdata  = mem_rdata;

  // Saturating contention counter, clear has priority
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (axi_req && acc_req && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_accel_mem_arbiter.sv
// Self-checking bench for accel_mem_arbiter: directed sequences, a vector table and
// randomized traffic against a behavioural model with its own SRAM image.
module tb_accel_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MAXB = 16;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          axi_req, axi_we, acc_req, acc_we, acc_lock, cnt_clr;
  logic [AW-1:0] axi_addr, acc_addr;
  logic [BW-1:0] axi_be, acc_be;
  logic [DW-1:0] axi_wdata, acc_wdata;
  logic          axi_gnt, acc_gnt, axi_rvalid, acc_rvalid;
  logic [DW-1:0] axi_rdata, acc_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [CW-1:0] conflict_cnt;

  accel_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MAXB), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .axi_req(axi_req), .axi_gnt(axi_gnt), .axi_addr(axi_addr), .axi_we(axi_we),
    .axi_be(axi_be), .axi_wdata(axi_wdata), .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata),
    .acc_req(acc_req), .acc_gnt(acc_gnt), .acc_addr(acc_addr), .acc_we(acc_we),
    .acc_be(acc_be), .acc_wdata(acc_wdata), .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata),
    .acc_lock(acc_lock),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cnt_clr(cnt_clr), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Environment SRAM, one-cycle read latency
  logic [DW-1:0] sram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < BW; b++)
          if (mem_be[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit            m_last_acc;
  int            m_run;
  bit            m_release;
  bit            m_pv, m_po_acc;
  logic [DW-1:0] m_pdata;
  int            m_cnt;

  // Per-cycle samples and predictions
  bit            e_axi, e_acc;
  logic          s_axi_gnt, s_acc_gnt, s_axi_rvalid, s_acc_rvalid;
  logic [DW-1:0] s_axi_rdata, s_acc_rdata;
  logic [CW-1:0] s_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last_acc = 0; m_run = 0; m_release = 0; m_pv = 0; m_po_acc = 0; m_cnt = 0;
  endtask

  // Called at posedge+1 with inputs applied; checks mid-cycle, commits, advances one clock
  task automatic run_cycle();
    bit            e_arv, e_crv, g_we;
    logic [AW-1:0] g_addr;
    logic [BW-1:0] g_be;
    logic [DW-1:0] g_wd;
    #3;
    e_axi = 0; e_acc = 0;
    if (rst_n) begin
      if (m_release) begin
        if (axi_req) e_axi = 1; else if (acc_req) e_acc = 1;
      end else if (m_run > 0 && acc_req && acc_lock) begin
        e_acc = 1;
      end else if (axi_req && acc_req) begin
        if (m_last_acc) e_axi = 1; else e_acc = 1;
      end else begin
        e_axi = axi_req; e_acc = acc_req;
      end
    end
    e_arv = rst_n && m_pv && !m_po_acc;
    e_crv = rst_n && m_pv && m_po_acc;
    g_addr = e_acc ? acc_addr : axi_addr;
    g_we   = e_acc ? acc_we : axi_we;
    g_be   = e_acc ? acc_be : axi_be;
    g_wd   = e_acc ? acc_wdata : axi_wdata;

    chk("axi_gnt", 64'(axi_gnt), 64'(e_axi));
    chk("acc_gnt", 64'(acc_gnt), 64'(e_acc));
    chk("mem_en", 64'(mem_en), 64'(e_axi | e_acc));
    if (e_axi || e_acc) begin
      chk("mem_addr", 64'(mem_addr), 64'(g_addr));
      chk("mem_we", 64'(mem_we), 64'(g_we));
      if (g_we) chk("mem_wdata", 64'(mem_wdata), 64'(g_wd));
    end
    chk("axi_rvalid", 64'(axi_rvalid), 64'(e_arv));
    chk("acc_rvalid", 64'(acc_rvalid), 64'(e_crv));
    if (e_arv) chk("axi_rdata", 64'(axi_rdata), 64'(m_pdata));
    if (e_crv) chk("acc_rdata", 64'(acc_rdata), 64'(m_pdata));
    chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));

    s_axi_gnt = axi_gnt; s_acc_gnt = acc_gnt;
    s_axi_rvalid = axi_rvalid; s_acc_rvalid = acc_rvalid;
    s_axi_rdata = axi_rdata; s_acc_rdata = acc_rdata; s_cnt = conflict_cnt;

    if (!rst_n) begin
      model_reset();
    end else begin
      m_pv = 0;
      if (e_axi || e_acc) begin
        m_last_acc = e_acc;
        m_po_acc   = e_acc;
        if (g_we) begin
          for (int b = 0; b < BW; b++)
            if (g_be[b]) ref_mem[g_addr][b*8 +: 8] = g_wd[b*8 +: 8];
        end else begin
          m_pv = 1;
          m_pdata = ref_mem[g_addr];
        end
      end
      if (!m_release && e_acc && acc_lock) begin
        m_run++;
        if (m_run == MAXB) begin m_run = 0; m_release = 1; end
      end else begin
        m_run = 0; m_release = 0;
      end
      if (cnt_clr) m_cnt = 0;
      else if (axi_req && acc_req && m_cnt < CMAX) m_cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    axi_req = 0; acc_req = 0; acc_lock = 0; cnt_clr = 0;
    axi_we = 0; acc_we = 0; axi_be = '1; acc_be = '1;
    axi_addr = '0; acc_addr = '0; axi_wdata = '0; acc_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    run_cycle();
    rst_n = 1;
  endtask

  typedef struct {
    bit axi_req, acc_req, acc_lock;
    bit exp_axi, exp_acc;
    int exp_cnt;
  } vec_t;

  initial begin
    vec_t vt [9];
    int   n_acc;
    bit   p_axi, p_acc;

    vt[0] = '{1,1,0, 0,1, 0};
    vt[1] = '{1,1,0, 1,0, 1};
    vt[2] = '{1,1,0, 0,1, 2};
    vt[3] = '{1,1,0, 1,0, 3};
    vt[4] = '{1,1,0, 0,1, 4};
    vt[5] = '{1,1,0, 1,0, 5};
    vt[6] = '{1,0,0, 1,0, 6};
    vt[7] = '{0,1,0, 0,1, 6};
    vt[8] = '{0,0,0, 0,0, 6};

    for (int i = 0; i < (1<<AW); i++) begin sram[i] = '0; ref_mem[i] = '0; end
    mem_rdata = '0;
    model_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    // Requests during reset must not be granted
    axi_req = 1; acc_req = 1;
    run_cycle();
    chk("reset_no_gnt", 64'({s_axi_gnt, s_acc_gnt}), 64'(0));
    do_reset();

    // AXI write then read-back
    axi_req = 1; axi_we = 1; axi_addr = 10'h010; axi_be = '1; axi_wdata = 32'hA5A5_0001;
    run_cycle();
    chk("t1_wr_gnt", 64'(s_axi_gnt), 64'(1));
    axi_we = 0;
    run_cycle();
    chk("t1_rd_gnt", 64'(s_axi_gnt), 64'(1));
    idle_inputs();
    run_cycle();
    chk("t1_rvalid", 64'(s_axi_rvalid), 64'(1));
    chk("t1_rdata", 64'(s_axi_rdata), 64'(32'hA5A5_0001));
    chk("t1_acc_rvalid", 64'(s_acc_rvalid), 64'(0));

    // Back-to-back reads from opposite sides, no crossover
    acc_req = 1; acc_we = 1; acc_addr = 10'h3FF; acc_wdata = 32'hDEAD_BEEF;
    run_cycle();
    acc_we = 0;
    run_cycle();
    acc_req = 0; axi_req = 1; axi_addr = 10'h000;
    run_cycle();
    chk("t4_acc_rvalid", 64'(s_acc_rvalid), 64'(1));
    chk("t4_acc_rdata", 64'(s_acc_rdata), 64'(32'hDEAD_BEEF));
    chk("t4_axi_rvalid_early", 64'(s_axi_rvalid), 64'(0));
    idle_inputs();
    run_cycle();
    chk("t4_axi_rvalid", 64'(s_axi_rvalid), 64'(1));
    chk("t4_acc_rvalid_late", 64'(s_acc_rvalid), 64'(0));

    // Reset right after an accelerator read grant drops the return
    acc_req = 1; acc_addr = 10'h3FF;
    run_cycle();
    idle_inputs();
    rst_n = 0;
    run_cycle();
    chk("t5_rvalid_in_rst", 64'(s_acc_rvalid), 64'(0));
    rst_n = 1;
    run_cycle();
    chk("t5_rvalid_after", 64'(s_acc_rvalid), 64'(0));
    chk("t5_cnt", 64'(s_cnt), 64'(0));

    // Round-robin vector table from a fresh reset
    do_reset();
    foreach (vt[i]) begin
      axi_req = vt[i].axi_req; acc_req = vt[i].acc_req; acc_lock = vt[i].acc_lock;
      run_cycle();
      chk($sformatf("vec%0d_axi_gnt", i), 64'(s_axi_gnt), 64'(vt[i].exp_axi));
      chk($sformatf("vec%0d_acc_gnt", i), 64'(s_acc_gnt), 64'(vt[i].exp_acc));
      chk($sformatf("vec%0d_cnt", i), 64'(s_cnt), 64'(vt[i].exp_cnt));
    end

    // Burst lock with forced release
    do_reset();
    axi_req = 1; acc_req = 1; acc_lock = 1;
    n_acc = 0;
    for (int i = 0; i < MAXB; i++) begin
      run_cycle();
      if (s_acc_gnt) n_acc++;
    end
    chk("t3_acc_burst", 64'(n_acc), 64'(MAXB));
    run_cycle();
    chk("t3_release_axi", 64'(s_axi_gnt), 64'(1));
    acc_lock = 0;
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      chk($sformatf("t3_rr%0d_acc", i), 64'(s_acc_gnt), 64'((i % 2) == 0));
    end

    // Counter saturation and clear priority
    do_reset();
    axi_req = 1; acc_req = 1;
    repeat (CMAX + 5) run_cycle();
    chk("t6_saturated", 64'(s_cnt), 64'(CMAX));
    cnt_clr = 1;
    run_cycle();
    idle_inputs();
    run_cycle();
    chk("t6_cleared", 64'(s_cnt), 64'(0));

    // Randomized traffic with requests held until granted
    do_reset();
    p_axi = 0; p_acc = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!p_axi && ($urandom % 3 == 0)) begin
        p_axi = 1; axi_we = 1'($urandom); axi_addr = AW'($urandom_range(0, 15));
        axi_be = BW'($urandom_range(1, 15)); axi_wdata = $urandom;
      end
      if (!p_acc && ($urandom % 2 == 0)) begin
        p_acc = 1; acc_we = 1'($urandom); acc_addr = AW'($urandom_range(0, 15));
        acc_be = BW'($urandom_range(1, 15)); acc_wdata = $urandom;
      end
      axi_req = p_axi; acc_req = p_acc;
      acc_lock = p_acc && ($urandom % 4 != 0);
      cnt_clr = ($urandom % 50 == 0);
      rst_n = ($urandom % 200 != 0);
      run_cycle();
      if (e_axi) p_axi = 0;
      if (e_acc) p_acc = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
